// File: rtl/keypad_decoder.sv
// 4x4 keypad receiver: aligns row/column samples, debounces a single key press,
// and queues its {row,col} code in a show-ahead FIFO drained by valid/ready.
module keypad_decoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] kpr,
  input  logic [3:0] kpc,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_down,
  output logic       overflow,
  output logic [1:0] state_dbg
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   FILL_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   FILL_FULL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

  // Handshake: an entry is consumed on any rising edge where key_valid && key_ready;
  // key_code is stable whenever key_valid is high and is never retracted before the pop.

  function automatic logic one_low(input logic [3:0] v);
    logic [3:0] x;
    x = ~v;
    return (x != 4'h0) && ((x & (x - 4'h1)) == 4'h0);
  endfunction

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    case (v)
      4'b1110: return 2'd0;
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  logic [3:0] kpr_s1_q, kpr_s1_d, kpr_s2_q, kpr_s2_d;
  logic [3:0] kpc_d1_q, kpc_d1_d, kpc_d2_q, kpc_d2_d;
  state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] cand_q, cand_d;
  logic       key_down_q, key_down_d;
  logic       overflow_q, overflow_d;
  logic [3:0] mem_q [FIFO_DEPTH];
  logic [3:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   fill_q, fill_d;

  logic       sample_valid;
  logic [3:0] sample_code;
  logic       push_req, push_ok, pop, full;

  // kpc takes the same two-register path as kpr so a row sample always pairs with
  // the column strobe that produced it.
  always_comb begin
    kpr_s1_d = kpr;
    kpr_s2_d = kpr_s1_q;
    kpc_d1_d = kpc;
    kpc_d2_d = kpc_d1_q;
  end

  assign sample_valid = one_low(kpr_s2_q) && one_low(kpc_d2_q);
  assign sample_code  = {low_idx(kpr_s2_q), low_idx(kpc_d2_q)};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      kpr_s1_q   <= 4'hF;
      kpr_s2_q   <= 4'hF;
      kpc_d1_q   <= 4'hF;
      kpc_d2_q   <= 4'hF;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cand_q     <= 4'h0;
      key_down_q <= 1'b0;
    end else begin
      kpr_s1_q   <= kpr_s1_d;
      kpr_s2_q   <= kpr_s2_d;
      kpc_d1_q   <= kpc_d1_d;
      kpc_d2_q   <= kpc_d2_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      key_down_q <= key_down_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    case (state_q)
      S_IDLE: begin
        if (sample_valid) begin
          cand_d  = sample_code;
          cnt_d   = '0;
          state_d = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (!sample_valid || (sample_code != cand_q)) state_d = S_IDLE;
        else if (cnt_q == CNT_LAST)                   state_d = S_HELD;
        else                                          cnt_d   = cnt_q + CNT_ONE;
      end
      S_HELD: begin
        if (kpr_s2_q == 4'hF) begin
          cnt_d   = '0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (kpr_s2_q != 4'hF)       state_d = S_HELD;
        else if (cnt_q == CNT_LAST) state_d = S_IDLE;
        else                        cnt_d   = cnt_q + CNT_ONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    push_req   = (state_q == S_DEBOUNCE) && sample_valid &&
                 (sample_code == cand_q) && (cnt_q == CNT_LAST);
    key_down_d = (state_d == S_HELD) || (state_d == S_RELEASE);
  end

  assign full    = (fill_q == FILL_FULL);
  assign pop     = key_valid && key_ready;
  assign push_ok = push_req && (!full || pop);

  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    overflow_d = overflow_q || (push_req && !push_ok);
    if (push_ok) begin
      mem_d[wr_ptr_q] = cand_q;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop})
      2'b10:   fill_d = fill_q + FILL_ONE;
      2'b01:   fill_d = fill_q - FILL_ONE;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 4'h0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
    end
  end

  assign key_valid = (fill_q != '0);
  assign key_code  = key_valid ? mem_q[rd_ptr_q] : 4'h0;
  assign key_down  = key_down_q;
  assign overflow  = overflow_q;
  assign state_dbg = state_q;

endmodule
